// File: rtl/ram_line_fetch.sv
// Cache-side controller for the synchronous RAM: single-word writes and line fills (optional wipe via RAM_LINE_FETCH_WIPE_EN).
// Latency: fill words return on consecutive cycles starting 2 cycles after acceptance; wr_ack 2 cycles after acceptance.
// Backpressure: req_ready only while idle; requests seen while busy are dropped, never queued.
module ram_line_fetch #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned LW_BITS = 2
) (
    input  logic               clk,
    input  logic               clr,
`ifdef RAM_LINE_FETCH_WIPE_EN
    input  logic               wipe_req,
`endif
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rw,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic [LW_BITS-1:0] rsp_idx,
    output logic               rsp_last,
    output logic               wr_ack,
    output logic               ram_enab,
    output logic               ram_rw,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_wdata,
    input  logic [D_WIDTH-1:0] ram_rdata,
    output logic               ram_clr_n
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
`ifdef RAM_LINE_FETCH_WIPE_EN
        WIPE,
`endif
        WRITE
    } state_t;

    localparam logic [LW_BITS-1:0] LAST_IDX = '1;
    localparam logic [LW_BITS-1:0] ONE_IDX  = LW_BITS'(1);

    state_t             state;
    logic [A_WIDTH-1:0] base;
    // Index of the next address to issue; the word returning now is cnt-1.
    logic [LW_BITS-1:0] cnt;
    logic [A_WIDTH-1:0] aligned_addr;

    assign aligned_addr = {req_addr[A_WIDTH-1:LW_BITS], {LW_BITS{1'b0}}};
    assign rsp_data     = ram_rdata;

`ifdef RAM_LINE_FETCH_WIPE_EN
    assign req_ready = (state == IDLE) && !wipe_req;
`else
    assign req_ready = (state == IDLE);
    assign ram_clr_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            base      <= '0;
            cnt       <= '0;
            ram_enab  <= 1'b0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
            rsp_last  <= 1'b0;
            wr_ack    <= 1'b0;
`ifdef RAM_LINE_FETCH_WIPE_EN
            ram_clr_n <= 1'b1;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            wr_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    ram_enab <= 1'b0;
                    ram_rw   <= 1'b0;
`ifdef RAM_LINE_FETCH_WIPE_EN
                    if (wipe_req) begin
                        ram_clr_n <= 1'b0;
                        state     <= WIPE;
                    end else
`endif
                    if (req_valid) begin
                        if (req_rw) begin
                            ram_enab  <= 1'b1;
                            ram_rw    <= 1'b1;
                            ram_addr  <= req_addr;
                            ram_wdata <= req_wdata;
                            state     <= WRITE;
                        end else begin
                            base     <= aligned_addr;
                            ram_enab <= 1'b1;
                            ram_addr <= aligned_addr;
                            cnt      <= ONE_IDX;
                            state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    ram_addr  <= base + A_WIDTH'(cnt);
                    rsp_valid <= 1'b1;
                    rsp_idx   <= cnt - ONE_IDX;
                    cnt       <= cnt + ONE_IDX;
                    if (cnt == LAST_IDX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last address is already at the RAM; just collect its word.
                    ram_enab  <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_idx   <= LAST_IDX;
                    rsp_last  <= 1'b1;
                    state     <= IDLE;
                end
                WRITE: begin
                    ram_enab <= 1'b0;
                    ram_rw   <= 1'b0;
                    wr_ack   <= 1'b1;
                    state    <= IDLE;
                end
`ifdef RAM_LINE_FETCH_WIPE_EN
                WIPE: begin
                    ram_clr_n <= 1'b1;
                    wr_ack    <= 1'b1;
                    state     <= IDLE;
                end
`endif
                default: begin
                    ram_enab <= 1'b0;
                    ram_rw   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_line_fetch.sv
// Bench for ram_line_fetch: behavioural sync RAM, reference memory and scoreboards for issued addresses and fill words.
// All sampling and driving happen at the falling edge; the DUT acts on the rising edge.
module tb_ram_line_fetch;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
        logic       last;
    } rsp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_idx;
    logic       rsp_last;
    logic       wr_ack;
    logic       ram_enab;
    logic       ram_rw;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       ram_clr_n;
`ifdef RAM_LINE_FETCH_WIPE_EN
    logic       wipe_req = 1'b0;
`endif

    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_dat = 8'h00;
    logic [7:0] ram_mem [256];
    logic [7:0] model_mem [256];

    rsp_t       exp_q [$];
    logic [7:0] addr_q [$];
    int         tests = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ram_line_fetch dut (
        .clk       (clk),
        .clr       (clr),
`ifdef RAM_LINE_FETCH_WIPE_EN
        .wipe_req  (wipe_req),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_idx   (rsp_idx),
        .rsp_last  (rsp_last),
        .wr_ack    (wr_ack),
        .ram_enab  (ram_enab),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_clr_n (ram_clr_n)
    );

    // Synchronous RAM: reads and writes on the rising edge, clear while ram_clr_n is low.
    always @(posedge clk) begin
        if (ram_clr_n === 1'b0) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
        end else if (ld_en) begin
            ram_mem[ld_addr] <= ld_dat;
        end else if (ram_enab === 1'b1) begin
            if (ram_rw === 1'b1) ram_mem[ram_addr] <= ram_wdata;
            else ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Scoreboard pop for whatever the DUT presents in the current cycle.
    task automatic sb_check();
        rsp_t       e;
        logic [7:0] a;
        if (ram_enab === 1'b1 && ram_rw === 1'b0) begin
            tests++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL read_issue: unexpected ram_addr %02h, none expected", ram_addr);
            end else begin
                a = addr_q.pop_front();
                if (ram_addr !== a) begin
                    errors++;
                    $display("FAIL read_addr: got %02h, expected %02h", ram_addr, a);
                end
            end
        end
        if (rsp_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: data %02h idx %0d with empty scoreboard", rsp_data, rsp_idx);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e.d || rsp_idx !== e.idx || rsp_last !== e.last) begin
                    errors++;
                    $display("FAIL rsp_word: got d=%02h idx=%0d last=%0b, expected d=%02h idx=%0d last=%0b",
                             rsp_data, rsp_idx, rsp_last, e.d, e.idx, e.last);
                end
            end
        end
        if (rsp_valid === 1'b1 || wr_ack === 1'b1) begin
            tests++;
            if (rsp_valid === 1'b1 && wr_ack === 1'b1) begin
                errors++;
                $display("FAIL rsp_ack_overlap: rsp_valid=%0b wr_ack=%0b, expected not both", rsp_valid, wr_ack);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sb_check();
    endtask

    task automatic load(input logic [7:0] addr, input logic [7:0] dat);
        ld_en = 1'b1; ld_addr = addr; ld_dat = dat;
        model_mem[addr] = dat;
        cycle();
        ld_en = 1'b0;
    endtask

    task automatic push_line(input logic [7:0] addr);
        logic [7:0] base;
        rsp_t       e;
        base = {addr[7:2], 2'b00};
        for (int i = 0; i < 4; i++) begin
            e.d    = model_mem[base + 8'(i)];
            e.idx  = 2'(i);
            e.last = (i == 3);
            exp_q.push_back(e);
            addr_q.push_back(base + 8'(i));
        end
    endtask

    // Presents one request, waits for acceptance, returns at the falling edge of the first busy cycle.
    task automatic issue(input logic rw, input logic [7:0] addr, input logic [7:0] dat);
        bit ok = 0;
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = dat;
        for (int i = 0; i < 40; i++) begin
            if (req_ready === 1'b1) begin ok = 1; break; end
            cycle();
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%0b, expected 1 within 40 cycles", req_ready);
        end else begin
            if (rw) model_mem[addr] = dat;
            else push_line(addr);
        end
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && addr_q.size() == 0 && req_ready === 1'b1) begin ok = 1; break; end
            cycle();
        end
        tests++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: %0d words and %0d addresses outstanding, expected 0", exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) cycle();
        tests++;
        if ({ram_enab, ram_rw, rsp_valid, rsp_last, wr_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: enab/rw/rv/last/ack=%05b, expected 00000", {ram_enab, ram_rw, rsp_valid, rsp_last, wr_ack});
        end
        tests++;
        if (ram_addr !== 8'h00 || ram_wdata !== 8'h00 || rsp_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%02h wdata=%02h idx=%0d, expected 00 00 0", ram_addr, ram_wdata, rsp_idx);
        end
        tests++;
        if (ram_clr_n !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ram_clr_n=%0b req_ready=%0b, expected 1 1", ram_clr_n, req_ready);
        end
        clr = 1'b0;
        cycle();
    endtask

    task automatic test_line_read();
        logic [7:0] init [8] = '{8'h0F, 8'h3F, 8'h7F, 8'hEF, 8'h18, 8'h18, 8'hDB, 8'h99};
        for (int i = 0; i < 8; i++) load(8'(i), init[i]);
        issue(1'b0, 8'h05, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            tests++;
            if (ram_enab !== (k <= 4) || rsp_valid !== (k >= 2 && k <= 5) || req_ready !== (k >= 5)) begin
                errors++;
                $display("FAIL line_timing c%0d: enab=%0b rv=%0b rdy=%0b, expected %0b %0b %0b", k,
                         ram_enab, rsp_valid, req_ready, k <= 4, k >= 2 && k <= 5, k >= 5);
            end
            if (k < 6) cycle();
        end
        wait_idle();
    endtask

    task automatic test_write_read();
        issue(1'b1, 8'h02, 8'hA5);
        tests++;
        if (ram_enab !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 8'h02 || ram_wdata !== 8'hA5 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_drive: enab=%0b rw=%0b addr=%02h wd=%02h ack=%0b, expected 1 1 02 a5 0",
                     ram_enab, ram_rw, ram_addr, ram_wdata, wr_ack);
        end
        cycle();
        tests++;
        if (wr_ack !== 1'b1 || req_ready !== 1'b1 || ram_enab !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: ack=%0b rdy=%0b enab=%0b, expected 1 1 0", wr_ack, req_ready, ram_enab);
        end
        cycle();
        tests++;
        if (wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_pulse: ack=%0b, expected 0", wr_ack);
        end
        issue(1'b0, 8'h00, 8'h00);
        wait_idle();
    endtask

    task automatic test_top_line();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 8'hFC + 8'(i), vals[i]);
            wait_idle();
        end
        issue(1'b0, 8'hFE, 8'h00);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) load(8'h80 + 8'(i), 8'hC0 + 8'(i));
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h01;
        tests++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ready: rdy=%0b, expected 1", req_ready);
        end
        push_line(8'h00);
        cycle();
        req_addr = 8'h81;
        for (int k = 1; k <= 4; k++) begin
            tests++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy c%0d: rdy=%0b, expected 0", k, req_ready);
            end
            cycle();
        end
        tests++;
        if (req_ready !== 1'b1 || rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handover: rdy=%0b last=%0b, expected 1 1", req_ready, rsp_last);
        end
        push_line(8'h81);
        cycle();
        req_valid = 1'b0;
        tests++;
        if (ram_enab !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: enab=%0b rdy=%0b, expected 1 0", ram_enab, req_ready);
        end
        wait_idle();
    endtask

    task automatic test_clr_mid_fill();
        for (int i = 0; i < 4; i++) load(8'h08 + 8'(i), 8'h50 + 8'(i));
        issue(1'b0, 8'h08, 8'h00);
        cycle();
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        tests++;
        if (ram_enab !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_mid: enab=%0b rv=%0b rdy=%0b, expected 0 0 1", ram_enab, rsp_valid, req_ready);
        end
        exp_q.delete();
        addr_q.delete();
        cycle();
        issue(1'b0, 8'h04, 8'h00);
        wait_idle();
    endtask

`ifdef RAM_LINE_FETCH_WIPE_EN
    task automatic test_wipe();
        rsp_t e;
        wipe_req = 1'b1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h00;
        tests++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wipe_priority: rdy=%0b, expected 0", req_ready);
        end
        cycle();
        wipe_req = 1'b0;
        tests++;
        if (ram_clr_n !== 1'b0 || ram_enab !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wipe_pulse: clr_n=%0b enab=%0b rdy=%0b, expected 0 0 0", ram_clr_n, ram_enab, req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            e.d = 8'h00; e.idx = 2'(i); e.last = (i == 3);
            exp_q.push_back(e);
            addr_q.push_back(8'(i));
        end
        cycle();
        tests++;
        if (ram_clr_n !== 1'b1 || wr_ack !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wipe_done: clr_n=%0b ack=%0b rdy=%0b, expected 1 1 1", ram_clr_n, wr_ack, req_ready);
        end
        cycle();
        req_valid = 1'b0;
        tests++;
        if (ram_clr_n !== 1'b1 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL wipe_once: clr_n=%0b ack=%0b, expected 1 0", ram_clr_n, wr_ack);
        end
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_line_read();
        test_write_read();
        test_top_line();
        test_back_to_back();
        test_clr_mid_fill();
`ifdef RAM_LINE_FETCH_WIPE_EN
        test_wipe();
`endif
        repeat (3) cycle();
        tests++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d words %0d addresses, expected 0 0", exp_q.size(), addr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
